sprite_anim_scheduler: RTL and testbench
========================================

Name: sprite_anim_scheduler

Overview:
- Time-multiplexes one shared bounce-update datapath across N_SPR square sprites.
- Each selected frame strobe (vblank start) steps sprites 0..N_SPR-1, one per clock.
- Provides run, single-step, speed-divider and frame-count control.
- Exposes the edge coordinates of any sprite to the renderer through an indexed combinational read port.

Parameters:
- N_SPR, 4, number of sprites (1..16)
- H_SIZE, 16, half square width
- D_WIDTH, 640, display width
- D_HEIGHT, 480, display height
- IX0, 100, sprite 0 initial centre x
- IX_STEP, 100, x offset per sprite index
- IY0, 100, sprite 0 initial centre y
- IY_STEP, 60, y offset per sprite index

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset: synchronous, active-high; clock i_clk
- i_frame_stb  in  1  one-cycle pulse at start of vertical blank
- i_run  in  1  continuous animation enable
- i_step  in  1  one-cycle pulse requesting exactly one update frame
- i_speed  in  3  frames per move = i_speed+1
- i_rd_idx  in  4  sprite index for read port
- o_x1, o_x2, o_y1, o_y2  out  12 each  left/right/top/bottom edges of sprite i_rd_idx
- o_busy  out  1  high while the update sweep runs
- o_frame_done  out  1  one-cycle pulse at sweep end
- o_frame_cnt  out  16  count of completed sweeps, wraps
- o_overrun  out  1  sticky: i_frame_stb arrived while busy

Behaviour:
- Per-sprite state k:
  - x[k], y[k] are 12 bits; x_dir[k] and y_dir[k]: 1 = right/down.
  - Init values: x = IX0 + k*IX_STEP, y = IY0 + k*IY_STEP, x_dir = ~k[0], y_dir = ~k[1] (y_dir = 1 when N_SPR = 1).
- Reset:
  - All sprites return to init values; FSM goes to IDLE.
  - Divider count, step_pend, o_frame_cnt and o_overrun clear to 0; o_busy = 0, o_frame_done = 0.
  - Reset mid-sweep aborts the sweep; partially updated sprites are also restored to init.
- i_step sets step_pend, which holds until consumed; i_step in the same cycle as reset is dropped.
- FSM states: IDLE, UPDATE, DONE.
- IDLE, on i_frame_stb:
  - If step_pend: go to UPDATE, clear step_pend, divider unchanged.
  - Else if i_run and div_cnt >= i_speed: go to UPDATE, div_cnt <= 0.
  - Else if i_run: div_cnt increments.
  - Else (not running): div_cnt <= 0.
- UPDATE, one sprite per cycle, idx 0..N_SPR-1:
  - o_busy = 1.
  - x <= x_dir ? x+1 : x-1; y likewise, using the old direction.
  - Direction update from the old position: x <= H_SIZE+1 sets x_dir=1; x >= D_WIDTH-H_SIZE-1 sets x_dir=0; y analogous with D_HEIGHT.
  - Arithmetic is 12-bit modulo.
  - After idx = N_SPR-1, go to DONE.
- DONE (1 cycle): o_frame_done = 1, o_frame_cnt increments, o_busy = 0, then IDLE.
- Latency: with stb in cycle 0, sprite k writes at edge k+1; done pulse in cycle N_SPR+1.
- i_frame_stb during UPDATE or DONE is ignored for scheduling and sets o_overrun.
- i_step during a sweep stays pending for the next strobe.
- Read port:
  - Combinational: o_x1 = x-H_SIZE, o_x2 = x+H_SIZE, o_y1 = y-H_SIZE, o_y2 = y+H_SIZE, all 12-bit.
  - i_rd_idx >= N_SPR drives all four outputs to 0.
  - Reads during a sweep may mix old and new sprite values; this is permitted.

Test Plan:
- Reset, then read idx 0 -> x1=84, x2=116, y1=84, y2=116. Read idx 1 -> centre (200,160).
- Timing: i_run=1, i_speed=0, one stb. Required: idx0 centre (101,101) and idx1 centre (199,161); o_busy high for 4 cycles; o_frame_done pulses in cycle 5; o_frame_cnt=1.
- Speed divider: i_speed=2, 9 strobes -> exactly 3 sweeps, o_frame_cnt=3, sprite0 centre (103,103).
- Step: i_run=0, pulse i_step, then 3 strobes -> exactly one sweep. A stb during the sweep sets o_overrun=1, which stays set.
- Bounce: i_run=1, i_speed=0, 524 sweeps -> sprite0 x=624. After 525 sweeps -> x=623, y=303, x_dir=0. Check idx 7 reads 0.
- Reset mid-sweep: assert i_rst in cycle 2 of a sweep -> all sprites at init values, o_busy=0, o_frame_cnt=0, no o_frame_done pulse.

Source files
------------

// File: rtl/sprite_anim_if.sv
// Control, status and renderer read-port bundle of the sprite animation scheduler.
// The master side drives requests and the read index; the slave side is the scheduler.
interface sprite_anim_if;
   logic        i_frame_stb;
   logic        i_run;
   logic        i_step;
   logic [2:0]  i_speed;
   logic [3:0]  i_rd_idx;
   logic [11:0] o_x1;
   logic [11:0] o_x2;
   logic [11:0] o_y1;
   logic [11:0] o_y2;
   logic        o_busy;
   logic        o_frame_done;
   logic [15:0] o_frame_cnt;
   logic        o_overrun;

   modport master (
      output i_frame_stb, i_run, i_step, i_speed, i_rd_idx,
      input  o_x1, o_x2, o_y1, o_y2, o_busy, o_frame_done, o_frame_cnt, o_overrun
   );

   modport slave (
      input  i_frame_stb, i_run, i_step, i_speed, i_rd_idx,
      output o_x1, o_x2, o_y1, o_y2, o_busy, o_frame_done, o_frame_cnt, o_overrun
   );
endinterface

// File: rtl/sprite_anim_scheduler.sv
// Bounces N_SPR square sprites with one shared update datapath, one sprite per clock
// after each accepted frame strobe; edges of any sprite are readable combinationally.
module sprite_anim_scheduler #(
   parameter int N_SPR    = 4,
   parameter int H_SIZE   = 16,
   parameter int D_WIDTH  = 640,
   parameter int D_HEIGHT = 480,
   parameter int IX0      = 100,
   parameter int IX_STEP  = 100,
   parameter int IY0      = 100,
   parameter int IY_STEP  = 60
) (
   input  logic         i_clk,
   input  logic         i_rst,
   sprite_anim_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [11:0] HS       = 12'(H_SIZE);
   localparam logic [11:0] X_LO     = 12'(H_SIZE + 1);
   localparam logic [11:0] X_HI     = 12'(D_WIDTH - H_SIZE - 1);
   localparam logic [11:0] Y_LO     = 12'(H_SIZE + 1);
   localparam logic [11:0] Y_HI     = 12'(D_HEIGHT - H_SIZE - 1);
   localparam logic [3:0]  LAST_IDX = 4'(N_SPR - 1);

   function automatic logic [11:0] init_x(input int k);
      return 12'(IX0 + k * IX_STEP);
   endfunction

   function automatic logic [11:0] init_y(input int k);
      return 12'(IY0 + k * IY_STEP);
   endfunction

   function automatic logic init_xdir(input int k);
      return ~k[0];
   endfunction

   function automatic logic init_ydir(input int k);
      return (N_SPR == 1) ? 1'b1 : ~k[1];
   endfunction

   state_t      state_q;
   logic [3:0]  idx_q;
   logic [2:0]  div_q;
   logic        step_pend_q;
   logic        busy_q;
   logic        done_q;
   logic [15:0] cnt_q;
   logic        overrun_q;
   logic [11:0] x_q [N_SPR];
   logic [11:0] y_q [N_SPR];
   logic [N_SPR-1:0] xdir_q;
   logic [N_SPR-1:0] ydir_q;

   logic [11:0] cur_x_s;
   logic [11:0] cur_y_s;
   logic        cur_xdir_s;
   logic        cur_ydir_s;
   logic [11:0] x_d;
   logic [11:0] y_d;
   logic        xdir_d;
   logic        ydir_d;
   logic [11:0] rd_x_s;
   logic [11:0] rd_y_s;
   logic        rd_valid_s;

   // Shared bounce datapath: select the sprite being swept and compute its next state.
   always_comb begin
      cur_x_s    = 12'd0;
      cur_y_s    = 12'd0;
      cur_xdir_s = 1'b0;
      cur_ydir_s = 1'b0;
      for (int k = 0; k < N_SPR; k++) begin
         cur_x_s    = cur_x_s | ((idx_q == 4'(k)) ? x_q[k] : 12'd0);
         cur_y_s    = cur_y_s | ((idx_q == 4'(k)) ? y_q[k] : 12'd0);
         cur_xdir_s = cur_xdir_s | ((idx_q == 4'(k)) & xdir_q[k]);
         cur_ydir_s = cur_ydir_s | ((idx_q == 4'(k)) & ydir_q[k]);
      end
      x_d = cur_xdir_s ? cur_x_s + 12'd1 : cur_x_s - 12'd1;
      y_d = cur_ydir_s ? cur_y_s + 12'd1 : cur_y_s - 12'd1;
      if (cur_x_s <= X_LO) begin
         xdir_d = 1'b1;
      end else if (cur_x_s >= X_HI) begin
         xdir_d = 1'b0;
      end else begin
         xdir_d = cur_xdir_s;
      end
      if (cur_y_s <= Y_LO) begin
         ydir_d = 1'b1;
      end else if (cur_y_s >= Y_HI) begin
         ydir_d = 1'b0;
      end else begin
         ydir_d = cur_ydir_s;
      end
   end

   // Renderer read port; indices beyond the sprite table read as all zero.
   always_comb begin
      rd_x_s = 12'd0;
      rd_y_s = 12'd0;
      for (int k = 0; k < N_SPR; k++) begin
         rd_x_s = rd_x_s | ((bus.i_rd_idx == 4'(k)) ? x_q[k] : 12'd0);
         rd_y_s = rd_y_s | ((bus.i_rd_idx == 4'(k)) ? y_q[k] : 12'd0);
      end
      rd_valid_s = ({1'b0, bus.i_rd_idx} < 5'(N_SPR));
   end

   assign bus.o_x1         = rd_valid_s ? rd_x_s - HS : 12'd0;
   assign bus.o_x2         = rd_valid_s ? rd_x_s + HS : 12'd0;
   assign bus.o_y1         = rd_valid_s ? rd_y_s - HS : 12'd0;
   assign bus.o_y2         = rd_valid_s ? rd_y_s + HS : 12'd0;
   assign bus.o_busy       = busy_q;
   assign bus.o_frame_done = done_q;
   assign bus.o_frame_cnt  = cnt_q;
   assign bus.o_overrun    = overrun_q;

   // Scheduler FSM, frame divider, step latch and sprite state table.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= 4'd0;
         div_q       <= 3'd0;
         step_pend_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= 16'd0;
         overrun_q   <= 1'b0;
         for (int k = 0; k < N_SPR; k++) begin
            x_q[k]    <= init_x(k);
            y_q[k]    <= init_y(k);
            xdir_q[k] <= init_xdir(k);
            ydir_q[k] <= init_ydir(k);
         end
      end else begin
         done_q <= 1'b0;
         if (bus.i_step) begin
            step_pend_q <= 1'b1;
         end
         if (bus.i_frame_stb && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.i_frame_stb) begin
                  if (step_pend_q) begin
                     // A step arriving with the consuming strobe stays pending.
                     step_pend_q <= bus.i_step;
                     state_q     <= ST_UPDATE;
                     busy_q      <= 1'b1;
                     idx_q       <= 4'd0;
                  end else if (bus.i_run && (div_q >= bus.i_speed)) begin
                     div_q   <= 3'd0;
                     state_q <= ST_UPDATE;
                     busy_q  <= 1'b1;
                     idx_q   <= 4'd0;
                  end else if (bus.i_run) begin
                     div_q <= div_q + 3'd1;
                  end else begin
                     div_q <= 3'd0;
                  end
               end
            end
            ST_UPDATE: begin
               for (int k = 0; k < N_SPR; k++) begin
                  if (idx_q == 4'(k)) begin
                     x_q[k]    <= x_d;
                     y_q[k]    <= y_d;
                     xdir_q[k] <= xdir_d;
                     ydir_q[k] <= ydir_d;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cnt_q   <= cnt_q + 16'd1;
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_anim_scheduler.sv
// Scoreboard bench for sprite_anim_scheduler: a bench-side model predicts each sweep
// at strobe time and the per-scenario tasks compare the DUT against those predictions.
module tb_sprite_anim_scheduler;

   localparam int N = 4;

   typedef struct packed {
      logic [15:0]       cnt;
      logic [3:0][11:0]  x;
      logic [3:0][11:0]  y;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   sprite_anim_if bus();

   sprite_anim_scheduler #(.N_SPR(N)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests   = 0;
   int n_fail    = 0;
   int done_seen = 0;

   rec_t        exp_q[$];
   rec_t        rec;
   logic [11:0] m_x [N];
   logic [11:0] m_y [N];
   logic        m_xd [N];
   logic        m_yd [N];
   logic [2:0]  m_div;
   logic        m_step;
   logic [15:0] m_cnt;
   logic [47:0] got_e;
   logic [47:0] exp_e;

   always @(negedge clk) begin
      if (bus.o_frame_done === 1'b1) done_seen++;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         logic [3:0] kb;
         kb      = 4'(k);
         m_x[k]  = 12'(100 + k * 100);
         m_y[k]  = 12'(100 + k * 60);
         m_xd[k] = ~kb[0];
         m_yd[k] = ~kb[1];
      end
      m_div  = 3'd0;
      m_step = 1'b0;
      m_cnt  = 16'd0;
      exp_q.delete();
   endtask

   task automatic model_sweep();
      rec_t r;
      for (int k = 0; k < N; k++) begin
         logic [11:0] ox;
         logic [11:0] oy;
         ox     = m_x[k];
         oy     = m_y[k];
         m_x[k] = m_xd[k] ? ox + 12'd1 : ox - 12'd1;
         m_y[k] = m_yd[k] ? oy + 12'd1 : oy - 12'd1;
         if (ox <= 12'd17) m_xd[k] = 1'b1;
         else if (ox >= 12'd623) m_xd[k] = 1'b0;
         if (oy <= 12'd17) m_yd[k] = 1'b1;
         else if (oy >= 12'd463) m_yd[k] = 1'b0;
         r.x[k] = m_x[k];
         r.y[k] = m_y[k];
      end
      m_cnt = m_cnt + 16'd1;
      r.cnt = m_cnt;
      exp_q.push_back(r);
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.i_frame_stb = 1'b0;
      bus.i_step      = 1'b0;
      bus.i_run       = 1'b0;
      bus.i_speed     = 3'd0;
      bus.i_rd_idx    = 4'd0;
      tick(2);
      rst = 1'b0;
      model_reset();
   endtask

   // One-cycle strobe issued while the DUT is idle; the model decides whether it sweeps.
   task automatic pulse_stb();
      bus.i_frame_stb = 1'b1;
      if (m_step) begin
         m_step = 1'b0;
         model_sweep();
      end else if (bus.i_run && (m_div >= bus.i_speed)) begin
         m_div = 3'd0;
         model_sweep();
      end else if (bus.i_run) begin
         m_div = m_div + 3'd1;
      end else begin
         m_div = 3'd0;
      end
      tick();
      bus.i_frame_stb = 1'b0;
   endtask

   task automatic pulse_step();
      bus.i_step = 1'b1;
      m_step     = 1'b1;
      tick();
      bus.i_step = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({bus.o_busy, bus.o_frame_done, bus.o_overrun, bus.o_frame_cnt} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_status: got busy=%b done=%b ovr=%b cnt=%0d required all 0",
                  bus.o_busy, bus.o_frame_done, bus.o_overrun, bus.o_frame_cnt);
      end
      for (int k = 0; k < N; k++) begin
         bus.i_rd_idx = 4'(k);
         #1;
         got_e = {bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2};
         exp_e = {m_x[k] - 12'd16, m_x[k] + 12'd16, m_y[k] - 12'd16, m_y[k] + 12'd16};
         n_tests++;
         if (got_e !== exp_e) begin
            n_fail++;
            $display("FAIL reset_sprite%0d: got %h required %h", k, got_e, exp_e);
         end
      end
      bus.i_rd_idx = 4'd1;
      #1;
      n_tests++;
      if ({bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2} !== {12'd184, 12'd216, 12'd144, 12'd176}) begin
         n_fail++;
         $display("FAIL reset_idx1_edges: got %0d %0d %0d %0d required 184 216 144 176",
                  bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2);
      end
   endtask

   task automatic test_timing();
      logic [7:0] busy_m;
      logic [7:0] done_m;
      do_reset();
      bus.i_run   = 1'b1;
      bus.i_speed = 3'd0;
      busy_m      = 8'd0;
      done_m      = 8'd0;
      pulse_stb();
      for (int c = 1; c <= 6; c++) begin
         busy_m[c] = bus.o_busy;
         done_m[c] = bus.o_frame_done;
         tick();
      end
      n_tests++;
      if (busy_m !== 8'b0001_1110) begin
         n_fail++;
         $display("FAIL timing_busy: got cycle mask %b required 00011110", busy_m);
      end
      n_tests++;
      if (done_m !== 8'b0010_0000) begin
         n_fail++;
         $display("FAIL timing_done: got cycle mask %b required 00100000", done_m);
      end
      rec = exp_q.pop_front();
      n_tests++;
      if (bus.o_frame_cnt !== rec.cnt) begin
         n_fail++;
         $display("FAIL timing_cnt: got %0d required %0d", bus.o_frame_cnt, rec.cnt);
      end
      for (int k = 0; k < N; k++) begin
         bus.i_rd_idx = 4'(k);
         #1;
         got_e = {bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2};
         exp_e = {rec.x[k] - 12'd16, rec.x[k] + 12'd16, rec.y[k] - 12'd16, rec.y[k] + 12'd16};
         n_tests++;
         if (got_e !== exp_e) begin
            n_fail++;
            $display("FAIL timing_sprite%0d: got %h required %h", k, got_e, exp_e);
         end
      end
      bus.i_rd_idx = 4'd1;
      #1;
      n_tests++;
      if ({bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2} !== {12'd183, 12'd215, 12'd145, 12'd177}) begin
         n_fail++;
         $display("FAIL timing_idx1_edges: got %0d %0d %0d %0d required 183 215 145 177",
                  bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2);
      end
   endtask

   task automatic test_speed();
      int base;
      do_reset();
      base        = done_seen;
      bus.i_run   = 1'b1;
      bus.i_speed = 3'd2;
      for (int i = 0; i < 9; i++) begin
         pulse_stb();
         tick(6);
      end
      n_tests++;
      if ((done_seen - base) !== exp_q.size() || (done_seen - base) !== 3) begin
         n_fail++;
         $display("FAIL speed_sweeps: got %0d required %0d", done_seen - base, exp_q.size());
      end
      rec = exp_q[$];
      exp_q.delete();
      n_tests++;
      if (bus.o_frame_cnt !== rec.cnt) begin
         n_fail++;
         $display("FAIL speed_cnt: got %0d required %0d", bus.o_frame_cnt, rec.cnt);
      end
      bus.i_rd_idx = 4'd0;
      #1;
      n_tests++;
      if ({bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2} !== {12'd87, 12'd119, 12'd87, 12'd119}) begin
         n_fail++;
         $display("FAIL speed_sprite0: got %0d %0d %0d %0d required 87 119 87 119",
                  bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2);
      end
   endtask

   task automatic test_step();
      int base;
      do_reset();
      base = done_seen;
      pulse_step();
      pulse_stb();
      bus.i_frame_stb = 1'b1;
      tick();
      bus.i_frame_stb = 1'b0;
      tick(6);
      n_tests++;
      if (bus.o_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL step_overrun_set: got %b required 1", bus.o_overrun);
      end
      pulse_stb();
      tick(6);
      n_tests++;
      if ((done_seen - base) !== 1 || exp_q.size() !== 1) begin
         n_fail++;
         $display("FAIL step_sweeps: got %0d required 1", done_seen - base);
      end
      n_tests++;
      if (bus.o_overrun !== 1'b1 || bus.o_frame_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL step_sticky: got ovr=%b cnt=%0d required ovr=1 cnt=1",
                  bus.o_overrun, bus.o_frame_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      do_reset();
      base = done_seen;
      pulse_step();
      pulse_stb();
      pulse_step();
      tick(5);
      pulse_stb();
      tick(6);
      n_tests++;
      if ((done_seen - base) !== exp_q.size() || (done_seen - base) !== 2) begin
         n_fail++;
         $display("FAIL b2b_sweeps: got %0d required %0d", done_seen - base, exp_q.size());
      end
      rec = exp_q[$];
      exp_q.delete();
      for (int k = 0; k < N; k++) begin
         bus.i_rd_idx = 4'(k);
         #1;
         got_e = {bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2};
         exp_e = {rec.x[k] - 12'd16, rec.x[k] + 12'd16, rec.y[k] - 12'd16, rec.y[k] + 12'd16};
         n_tests++;
         if (got_e !== exp_e) begin
            n_fail++;
            $display("FAIL b2b_sprite%0d: got %h required %h", k, got_e, exp_e);
         end
      end
   endtask

   task automatic test_bounce();
      do_reset();
      bus.i_run   = 1'b1;
      bus.i_speed = 3'd0;
      for (int i = 0; i < 524; i++) begin
         pulse_stb();
         tick(5);
      end
      bus.i_rd_idx = 4'd0;
      #1;
      n_tests++;
      if ({bus.o_x1, bus.o_x2} !== {12'd608, 12'd640}) begin
         n_fail++;
         $display("FAIL bounce_524_x: got %0d %0d required 608 640", bus.o_x1, bus.o_x2);
      end
      pulse_stb();
      tick(5);
      n_tests++;
      if ({bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2} !== {12'd607, 12'd639, 12'd287, 12'd319}) begin
         n_fail++;
         $display("FAIL bounce_525: got %0d %0d %0d %0d required 607 639 287 319",
                  bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2);
      end
      pulse_stb();
      tick(5);
      rec = exp_q[$];
      exp_q.delete();
      n_tests++;
      if (bus.o_x1 !== 12'd606 || bus.o_frame_cnt !== rec.cnt) begin
         n_fail++;
         $display("FAIL bounce_526_leftward: got x1=%0d cnt=%0d required x1=606 cnt=%0d",
                  bus.o_x1, bus.o_frame_cnt, rec.cnt);
      end
      for (int k = 0; k < N; k++) begin
         bus.i_rd_idx = 4'(k);
         #1;
         got_e = {bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2};
         exp_e = {rec.x[k] - 12'd16, rec.x[k] + 12'd16, rec.y[k] - 12'd16, rec.y[k] + 12'd16};
         n_tests++;
         if (got_e !== exp_e) begin
            n_fail++;
            $display("FAIL bounce_sprite%0d: got %h required %h", k, got_e, exp_e);
         end
      end
      bus.i_rd_idx = 4'd7;
      #1;
      n_tests++;
      if ({bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2} !== 48'd0) begin
         n_fail++;
         $display("FAIL bounce_idx7_zero: got %0d %0d %0d %0d required 0 0 0 0",
                  bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int base;
      do_reset();
      bus.i_run   = 1'b1;
      bus.i_speed = 3'd0;
      pulse_stb();
      tick(5);
      bus.i_frame_stb = 1'b1;
      tick(2);
      bus.i_frame_stb = 1'b0;
      base = done_seen;
      pulse_stb();
      tick();
      rst        = 1'b1;
      bus.i_step = 1'b1;
      tick();
      bus.i_step = 1'b0;
      tick();
      rst = 1'b0;
      model_reset();
      bus.i_run = 1'b0;
      tick(6);
      n_tests++;
      if (done_seen !== base || bus.o_busy !== 1'b0 || bus.o_frame_cnt !== 16'd0
          || bus.o_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_status: got dones=%0d busy=%b cnt=%0d ovr=%b required 0 0 0 0",
                  done_seen - base, bus.o_busy, bus.o_frame_cnt, bus.o_overrun);
      end
      for (int k = 0; k < N; k++) begin
         bus.i_rd_idx = 4'(k);
         #1;
         got_e = {bus.o_x1, bus.o_x2, bus.o_y1, bus.o_y2};
         exp_e = {m_x[k] - 12'd16, m_x[k] + 12'd16, m_y[k] - 12'd16, m_y[k] + 12'd16};
         n_tests++;
         if (got_e !== exp_e) begin
            n_fail++;
            $display("FAIL midrst_sprite%0d: got %h required %h", k, got_e, exp_e);
         end
      end
      base = done_seen;
      pulse_stb();
      tick(6);
      n_tests++;
      if (done_seen !== base || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL midrst_step_dropped: got %0d sweeps required 0", done_seen - base);
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_speed();
      test_step();
      test_back_to_back();
      test_bounce();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
